// File: rtl/bridge_1xn_if.sv
// Bus bundle between the CPU data port, the N-way decode bridge and its SRAM-like slaves.
// The bridge uses modport slave. The CPU and slave-side agents use modport master.
interface bridge_1xn_if #(
    parameter int N_SLAVES = 2
);
    logic                      cpu_data_en;
    logic [3:0]                cpu_data_wen;
    logic [31:0]               cpu_data_addr;
    logic [31:0]               cpu_data_wdata;
    logic [31:0]               cpu_data_rdata;

    logic [N_SLAVES-1:0]       slv_en;
    logic [4*N_SLAVES-1:0]     slv_wen;
    logic [32*N_SLAVES-1:0]    slv_addr;
    logic [32*N_SLAVES-1:0]    slv_wdata;
    logic [32*N_SLAVES-1:0]    slv_rdata;

    logic                      err_valid;
    logic [31:0]               err_addr;
    logic                      err_is_write;
    logic [7:0]                err_count;
    logic                      err_clr;

    modport slave (
        input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        output cpu_data_rdata,
        output slv_en, slv_wen, slv_addr, slv_wdata,
        input  slv_rdata,
        output err_valid, err_addr, err_is_write, err_count,
        input  err_clr
    );

    modport master (
        output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
        input  cpu_data_rdata,
        input  slv_en, slv_wen, slv_addr, slv_wdata,
        output slv_rdata,
        input  err_valid, err_addr, err_is_write, err_count,
        output err_clr
    );
endinterface

// File: rtl/bridge_1xn.sv
// N-way address-decode bridge from the CPU data port to SRAM-like slaves.
// It has an optional request register stage and captures the first unmapped access.
module bridge_1xn #(
    parameter int                     N_SLAVES       = 2,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE       = {32'h1faf0000, 32'h00000000},
    parameter logic [32*N_SLAVES-1:0] SLV_MASK       = {32'hffff0000, 32'hfffc0000},
    parameter int                     PIPE           = 0,
    parameter logic [31:0]            UNMAPPED_RDATA = 32'hdeadbeef
) (
    input  logic            clk,
    input  logic            reset,
    bridge_1xn_if.slave     bus
);

    logic [N_SLAVES-1:0] sel;
    logic                found;

    // Lowest index wins when windows overlap, so sel stays one-hot.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!found && ((bus.cpu_data_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    logic                req_en;
    logic [3:0]          req_wen;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [N_SLAVES-1:0] req_sel;

    generate
        if (PIPE != 0) begin : g_pipe
            logic                en_q;
            logic [3:0]          wen_q;
            logic [31:0]         addr_q;
            logic [31:0]         wdata_q;
            logic [N_SLAVES-1:0] sel_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    en_q    <= 1'b0;
                    wen_q   <= '0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    sel_q   <= '0;
                end else begin
                    en_q    <= bus.cpu_data_en;
                    wen_q   <= bus.cpu_data_wen;
                    addr_q  <= bus.cpu_data_addr;
                    wdata_q <= bus.cpu_data_wdata;
                    sel_q   <= sel;
                end
            end

            assign req_en    = en_q;
            assign req_wen   = wen_q;
            assign req_addr  = addr_q;
            assign req_wdata = wdata_q;
            assign req_sel   = sel_q;
        end else begin : g_comb
            assign req_en    = bus.cpu_data_en;
            assign req_wen   = bus.cpu_data_wen;
            assign req_addr  = bus.cpu_data_addr;
            assign req_wdata = bus.cpu_data_wdata;
            assign req_sel   = sel;
        end
    endgenerate

    // Only the strobe is steered; the rest of the request is broadcast.
    assign bus.slv_en    = {N_SLAVES{req_en}} & req_sel;
    assign bus.slv_wen   = {N_SLAVES{req_wen}};
    assign bus.slv_addr  = {N_SLAVES{req_addr}};
    assign bus.slv_wdata = {N_SLAVES{req_wdata}};

    logic unmapped;
    assign unmapped = req_en & ~(|req_sel);

    // sel_r all-zero after an access means that the access was unmapped. seen keeps rdata at 0 until the first access.
    logic [N_SLAVES-1:0] sel_r;
    logic                seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_r <= '0;
            seen  <= 1'b0;
        end else if (req_en) begin
            sel_r <= req_sel;
            seen  <= 1'b1;
        end
    end

    logic [31:0] rdata_mux;

    always_comb begin
        rdata_mux = UNMAPPED_RDATA;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_r[i]) begin
                rdata_mux = bus.slv_rdata[32*i +: 32];
            end
        end
    end

    assign bus.cpu_data_rdata = seen ? rdata_mux : 32'h0;

    logic        err_valid_q;
    logic [31:0] err_addr_q;
    logic        err_is_write_q;
    logic [7:0]  err_count_q;

    // A clear and a new unmapped access on the same edge: the new error wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_q    <= 1'b0;
            err_addr_q     <= '0;
            err_is_write_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            if (bus.err_clr) begin
                err_valid_q    <= 1'b0;
                err_addr_q     <= '0;
                err_is_write_q <= 1'b0;
                err_count_q    <= '0;
            end
            if (unmapped) begin
                if (!err_valid_q || bus.err_clr) begin
                    err_valid_q    <= 1'b1;
                    err_addr_q     <= req_addr;
                    err_is_write_q <= |req_wen;
                end
                if (bus.err_clr) begin
                    err_count_q <= 8'd1;
                end else if (err_count_q != 8'hff) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end
        end
    end

    assign bus.err_valid    = err_valid_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.err_is_write = err_is_write_q;
    assign bus.err_count    = err_count_q;

endmodule

// File: doc/bridge_1xn.md
Name: bridge_1xn

Overview:
- Parametrised N-way data-side address-decode bridge, successor to the fixed two-way data/confreg split.
- Sits between the CPU data SRAM-like port and N SRAM-like slaves (data RAM, confreg, future peripherals).
- Adds per-slave configurable address windows, an optional request pipeline stage and unmapped-access error capture.

Parameters:
N_SLAVES, 2, number of slave channels (1..8)
SLV_BASE, {32'h1faf0000, 32'h00000000}, packed 32*N base addresses; slave i in bits [32i+31:32i]
SLV_MASK, {32'hffff0000, 32'hfffc0000}, packed 32*N decode masks, same packing
PIPE, 0, 0 = combinational request path; 1 = request registered before reaching slaves
UNMAPPED_RDATA, 32'hdeadbeef, read data returned for unmapped reads

Ports:
clk  in  1  bridge/CPU clock
reset  in  1  synchronous, active-high reset
cpu_data_en  in  1  CPU access strobe
cpu_data_wen  in  4  byte write enables; 0 = read
cpu_data_addr  in  32  byte address
cpu_data_wdata  in  32  write data
cpu_data_rdata  out  32  read data
slv_en  out  N_SLAVES  per-slave strobe
slv_wen  out  4*N_SLAVES  per-slave byte enables
slv_addr  out  32*N_SLAVES  per-slave address (full, unmodified)
slv_wdata  out  32*N_SLAVES  per-slave write data
slv_rdata  in  32*N_SLAVES  per-slave read data; 1-cycle SRAM latency
err_valid  out  1  sticky unmapped-access flag
err_addr  out  32  address of first unmapped access since clear
err_is_write  out  1  first unmapped access was a write
err_count  out  8  saturating count of unmapped accesses
err_clr  in  1  clears the error state

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Decode: hit[i] = ((addr & SLV_MASK[i]) == SLV_BASE[i]). On overlapping windows the lowest index wins (one-hot sel). No hit means unmapped.
- Request, PIPE=0: slv_en[i] = cpu_data_en & sel[i]. wen, addr and wdata are broadcast to every slave; only the selected slave sees en.
- Request, PIPE=1: en, wen, addr, wdata and sel are registered, and slave outputs are driven from the registers. Reset clears en_q to 0. A new request is accepted every cycle, with no backpressure.
- Read return: sel_r is captured at the edge on which a slave sees its strobe (cycle T0 for PIPE=0, T0+1 for PIPE=1).
  - On the next cycle, cpu_data_rdata = slv_rdata[sel_r], or UNMAPPED_RDATA if sel_r is "none".
  - Read latency is 1 cycle (PIPE=0) or 2 cycles (PIPE=1).
  - sel_r updates only on accepted accesses, reads or writes. Between accesses, rdata follows the last-accessed slave's held output.
- Writes to unmapped space are dropped: no slv_en is asserted.
- Reset: all slv_en = 0, sel_r = none, cpu_data_rdata = 0 until the first access, err_valid = 0, err_addr = 0, err_is_write = 0, err_count = 0. A reset mid-pipeline discards the in-flight PIPE=1 request; it never reaches a slave.
- Error capture, evaluated at the point of slave strobe (i.e. pipelined when PIPE=1):
  - Any unmapped access increments err_count, saturating at 255.
  - If err_valid = 0, the access sets err_valid and captures err_addr and err_is_write = |wen.
  - While err_valid = 1, err_addr and err_is_write are frozen.
- err_clr: on the next edge, clears err_valid, err_addr, err_is_write and err_count.
  - If an unmapped access is captured on the same edge, the new error wins: err_valid = 1 with that address, err_count = 1.
- Width rules: no address translation; slaves receive the full 32-bit address and slice it themselves.

Test Plan:
- Defaults, PIPE=0: read 0x00000010 with slave0 returning 0x11223344 -> slv_en = 2'b01; cpu_data_rdata = 0x11223344 one cycle later. Read 0x1faf8000 -> slv_en = 2'b10; slave1 data returned after one cycle.
- Back-to-back: read slave0, read slave1, idle -> rdata sequence is slave0 data, slave1 data, then slave1 data held. Writes with wen = 4'hf reach only the decoded slave.
- Unmapped: write 0x00100000, then read 0x00200000 -> no slv_en asserted; err_valid = 1, err_addr = 0x00100000, err_is_write = 1, err_count = 2; read data = 0xdeadbeef.
- err_clr in the same cycle as an unmapped read of 0x00300000 -> err_valid = 1, err_addr = 0x00300000, err_is_write = 0, err_count = 1. Then 300 unmapped accesses -> err_count = 255.
- PIPE=1, N_SLAVES=3, overlapping windows on slaves 1 and 2 -> slave1 wins. slv_en appears 1 cycle after cpu_data_en; rdata appears 2 cycles after.
- Assert reset while a PIPE=1 write is in flight -> no slv_en on the following cycle; all outputs return to their reset values.
